if_stage: RTL and testbench

- Fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection and the F/D pipeline register.
- Drives the instruction-memory address and produces FD_Instr/FD_PC. FD_Instr is the D-stage instruction the hazard unit inspects.
- Consumes StallPC/StallFD from the hazard unit and the next-PC select and jr target from the D stage.
- Branches and jumps resolve in D with one architectural delay slot, so there is no flush.

---
 rtl/if_stage_if.sv | 28 ++
 rtl/if_stage.sv | 115 +++++++++++
 tb/tb_if_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage interface: hazard/D-stage controls, instruction-memory port,
// F/D pipeline register outputs and performance counters.
interface if_stage_if;
    logic        StallPC;
    logic        StallFD;
    logic [1:0]  NPC_Sel;
    logic [31:0] Jr_Target;
    logic [31:0] IM_Addr;
    logic [31:0] IM_Instr;
    logic [31:0] FD_Instr;
    logic [31:0] FD_PC;
    logic [31:0] FD_PC8;
    logic        FD_Valid;
    logic [31:0] Perf_Fetch;
    logic [31:0] Perf_Stall;

    // The fetch stage itself.
    modport master (
        input  StallPC, StallFD, NPC_Sel, Jr_Target, IM_Instr,
        output IM_Addr, FD_Instr, FD_PC, FD_PC8, FD_Valid, Perf_Fetch, Perf_Stall
    );

    // Hazard unit, D stage and instruction memory around it.
    modport slave (
        output StallPC, StallFD, NPC_Sel, Jr_Target, IM_Instr,
        input  IM_Addr, FD_Instr, FD_PC, FD_PC8, FD_Valid, Perf_Fetch, Perf_Stall
    );
endinterface

// File: rtl/if_stage.sv
// MIPS fetch stage: PC register, next-PC mux and F/D pipeline register.
// Optional fetch/stall counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.master  bus
);

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_sel_e;

    logic [31:0] pc_q,       pc_d;
    logic [31:0] fd_instr_q, fd_instr_d;
    logic [31:0] fd_pc_q,    fd_pc_d;
    logic        fd_valid_q, fd_valid_d;

    logic        stall;
    npc_sel_e    npc_sel;
    logic [31:0] seq_pc;
    logic [31:0] fd_pc4;
    logic [31:0] branch_off;
    logic [31:0] npc;

    // Either stall input freezes the whole stage so a mismatched pair
    // from the hazard unit can never drop or duplicate an instruction.
    assign stall   = bus.StallPC | bus.StallFD;
    assign npc_sel = npc_sel_e'(bus.NPC_Sel);

    // NOTE: every always_comb output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        seq_pc     = pc_q + 32'd4;
        fd_pc4     = fd_pc_q + 32'd4;
        branch_off = {{14{fd_instr_q[15]}}, fd_instr_q[15:0], 2'b00};
        npc        = seq_pc;
        case (npc_sel)
            NPC_SEQ:    npc = seq_pc;
            NPC_BRANCH: npc = fd_pc4 + branch_off;
            NPC_JUMP:   npc = {fd_pc4[31:28], fd_instr_q[25:0], 2'b00};
            NPC_JR:     npc = {bus.Jr_Target[31:2], 2'b00};
            default:    npc = seq_pc;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        fd_instr_d = fd_instr_q;
        fd_pc_d    = fd_pc_q;
        fd_valid_d = fd_valid_q;
        if (!stall) begin
            pc_d       = npc;
            fd_instr_d = bus.IM_Instr;
            fd_pc_d    = pc_q;
            fd_valid_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            fd_instr_q <= NOP_INSTR;
            fd_pc_q    <= RESET_PC;
            fd_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            fd_instr_q <= fd_instr_d;
            fd_pc_q    <= fd_pc_d;
            fd_valid_q <= fd_valid_d;
        end
    end

    assign bus.IM_Addr  = pc_q;
    assign bus.FD_Instr = fd_instr_q;
    assign bus.FD_PC    = fd_pc_q;
    assign bus.FD_PC8   = fd_pc_q + 32'd8;
    assign bus.FD_Valid = fd_valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (stall) perf_stall_d = perf_stall_q + 32'd1;
        else       perf_fetch_d = perf_fetch_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign bus.Perf_Fetch = perf_fetch_q;
    assign bus.Perf_Stall = perf_stall_q;
`else
    assign bus.Perf_Fetch = 32'd0;
    assign bus.Perf_Stall = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage: sequential fetch, branch/jump/jr
// redirects with delay slot, stalls, reset during stall and PC wrap.
module tb_if_stage;

    logic clk;
    logic reset;

    if_stage_if bus_if();

    if_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        spc;
        logic        sfd;
        logic [1:0]  sel;
        logic [31:0] jr;
        logic [31:0] im;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_valid;
    } vec_t;

    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_fetch = 0;
    logic [31:0] exp_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef IF_PERF_CNT_EN
        check({tag, " perf_fetch"}, bus_if.Perf_Fetch, exp_fetch);
        check({tag, " perf_stall"}, bus_if.Perf_Stall, exp_stall);
`else
        check({tag, " perf_fetch"}, bus_if.Perf_Fetch, 32'd0);
        check({tag, " perf_stall"}, bus_if.Perf_Stall, 32'd0);
`endif
    endtask

    task automatic drive(input vec_t v);
        reset            = v.rst;
        bus_if.StallPC   = v.spc;
        bus_if.StallFD   = v.sfd;
        bus_if.NPC_Sel   = v.sel;
        bus_if.Jr_Target = v.jr;
        bus_if.IM_Instr  = v.im;
    endtask

    initial begin
        //           rst  spc  sfd  sel    jr            im            addr          instr         pc            v
        // sequential fetch A, B, C
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h0000_000A,32'h0000_3004,32'h0000_000A,32'h0000_3000,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h0000_000B,32'h0000_3008,32'h0000_000B,32'h0000_3004,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h0000_000C,32'h0000_300C,32'h0000_000C,32'h0000_3008,1'b1});
        // backward beq (imm -2) at 3004, then forward beq (imm +3) at 3004
        vecs.push_back('{1'b1,1'b0,1'b0,2'b00,32'h0,       32'h0,        32'h0000_3000,32'h0000_0000,32'h0000_3000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h1111_1111,32'h0000_3004,32'h1111_1111,32'h0000_3000,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h1000_FFFE,32'h0000_3008,32'h1000_FFFE,32'h0000_3004,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b01,32'h0,       32'h2222_2222,32'h0000_3000,32'h2222_2222,32'h0000_3008,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h3333_3333,32'h0000_3004,32'h3333_3333,32'h0000_3000,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h1000_0003,32'h0000_3008,32'h1000_0003,32'h0000_3004,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b01,32'h0,       32'h4444_4444,32'h0000_3014,32'h4444_4444,32'h0000_3008,1'b1});
        // reset with a redirect pending, then jal at 3008 and jr
        vecs.push_back('{1'b1,1'b0,1'b0,2'b01,32'h0,       32'h9999_0000,32'h0000_3000,32'h0000_0000,32'h0000_3000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h5555_5555,32'h0000_3004,32'h5555_5555,32'h0000_3000,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h6666_6666,32'h0000_3008,32'h6666_6666,32'h0000_3004,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h0C00_0C10,32'h0000_300C,32'h0C00_0C10,32'h0000_3008,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b10,32'h0,       32'h7777_7777,32'h0000_3040,32'h7777_7777,32'h0000_300C,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h03E0_0008,32'h0000_3044,32'h03E0_0008,32'h0000_3040,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b11,32'h0000_3023,32'h8888_8888,32'h0000_3020,32'h8888_8888,32'h0000_3044,1'b1});
        // beq held by a 2-cycle stall, redirect applies once on release
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h9999_9999,32'h0000_3024,32'h9999_9999,32'h0000_3020,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h1000_0003,32'h0000_3028,32'h1000_0003,32'h0000_3024,1'b1});
        vecs.push_back('{1'b0,1'b1,1'b1,2'b01,32'h0,       32'hAAAA_0000,32'h0000_3028,32'h1000_0003,32'h0000_3024,1'b1});
        vecs.push_back('{1'b0,1'b1,1'b1,2'b01,32'h0,       32'hAAAA_0000,32'h0000_3028,32'h1000_0003,32'h0000_3024,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b01,32'h0,       32'hAAAA_0000,32'h0000_3034,32'hAAAA_0000,32'h0000_3028,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'hBBBB_0000,32'h0000_3038,32'hBBBB_0000,32'h0000_3034,1'b1});
        // single-sided stalls, then reset asserted during a stall
        vecs.push_back('{1'b0,1'b0,1'b1,2'b00,32'h0,       32'hCCCC_0000,32'h0000_3038,32'hBBBB_0000,32'h0000_3034,1'b1});
        vecs.push_back('{1'b0,1'b1,1'b0,2'b11,32'h0000_5000,32'hCCCC_0000,32'h0000_3038,32'hBBBB_0000,32'h0000_3034,1'b1});
        vecs.push_back('{1'b1,1'b1,1'b1,2'b00,32'h0,       32'hCCCC_0000,32'h0000_3000,32'h0000_0000,32'h0000_3000,1'b0});
        // PC wrap from FFFF_FFFC to 0
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'h03E0_0008,32'h0000_3004,32'h03E0_0008,32'h0000_3000,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b11,32'hFFFF_FFFF,32'hDDDD_0000,32'hFFFF_FFFC,32'hDDDD_0000,32'h0000_3004,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'hEEEE_0000,32'h0000_0000,32'hEEEE_0000,32'hFFFF_FFFC,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,2'b00,32'h0,       32'hFFFF_1111,32'h0000_0004,32'hFFFF_1111,32'h0000_0000,1'b1});

        // Reset state, held for two edges.
        drive('{1'b1,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,32'h0,32'h0,1'b0});
        repeat (2) @(posedge clk);
        #1;
        check("rst im_addr",  bus_if.IM_Addr,  32'h0000_3000);
        check("rst fd_instr", bus_if.FD_Instr, 32'h0000_0000);
        check("rst fd_pc",    bus_if.FD_PC,    32'h0000_3000);
        check("rst fd_pc8",   bus_if.FD_PC8,   32'h0000_3008);
        check("rst fd_valid", {31'd0, bus_if.FD_Valid}, 32'd0);
        check_perf("rst");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            if (vecs[i].rst) begin
                exp_fetch = 0;
                exp_stall = 0;
            end else if (vecs[i].spc | vecs[i].sfd) begin
                exp_stall = exp_stall + 1;
            end else begin
                exp_fetch = exp_fetch + 1;
            end
            check($sformatf("v%0d im_addr", i),  bus_if.IM_Addr,  vecs[i].e_addr);
            check($sformatf("v%0d fd_instr", i), bus_if.FD_Instr, vecs[i].e_instr);
            check($sformatf("v%0d fd_pc", i),    bus_if.FD_PC,    vecs[i].e_pc);
            check($sformatf("v%0d fd_pc8", i),   bus_if.FD_PC8,   vecs[i].e_pc + 32'd8);
            check($sformatf("v%0d fd_valid", i), {31'd0, bus_if.FD_Valid}, {31'd0, vecs[i].e_valid});
            check_perf($sformatf("v%0d", i));
        end

        // Counter sequence: reset, 5 fetches and 3 stalls in mixed order.
        @(negedge clk);
        drive('{1'b1,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,32'h0,32'h0,1'b0});
        @(negedge clk);
        exp_fetch = 0;
        exp_stall = 0;
        check_perf("perf after reset");
        for (int k = 0; k < 8; k++) begin
            drive('{1'b0, (k == 2), (k == 3 || k == 6), 2'b00, 32'h0, 32'h0000_0100 + k,
                    32'h0, 32'h0, 32'h0, 1'b0});
            @(negedge clk);
        end
        exp_fetch = 5;
        exp_stall = 3;
        check_perf("perf 5f3s");
        check("perf seq im_addr", bus_if.IM_Addr, 32'h0000_3014);
        check("perf seq fd_pc",   bus_if.FD_PC,   32'h0000_3010);
        check("perf seq fd_instr", bus_if.FD_Instr, 32'h0000_0107);
        drive('{1'b1,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,32'h0,32'h0,1'b0});
        @(negedge clk);
        exp_fetch = 0;
        exp_stall = 0;
        check_perf("perf cleared");
        check("final im_addr", bus_if.IM_Addr, 32'h0000_3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
